// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scanner for sev_clock output: latches one hh:mm frame at a time,
// scans the digits with optional anti-ghost blanking and drives a blinking colon on digit oh0.
module seg_scan_mux #(
   parameter int unsigned SCAN_DIV     = 4,
   parameter int unsigned BLANK_CYCLES = 1,
   parameter int unsigned COLON_DIV    = 32,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] oh1,
   input  logic [6:0] oh0,
   input  logic [6:0] om1,
   input  logic [6:0] om0,
   input  logic       lz_en,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int unsigned CW  = $clog2(SCAN_DIV);
   localparam int unsigned CCW = (COLON_DIV > 1) ? $clog2(COLON_DIV) : 1;
   localparam logic [CW-1:0]  CntMax    = CW'(SCAN_DIV - 1);
   localparam logic [CCW-1:0] ColMax    = CCW'(COLON_DIV - 1);
   localparam logic [6:0]     DigitZero = 7'b1111110;

   logic [CW-1:0]     cnt_q;
   logic [1:0]        d_q;
   logic [CCW-1:0]    ccnt_q;
   logic              colon_on_q;
   logic [3:0][6:0]   snap_q;
   logic [3:0][6:0]   snap_d;
   logic              frame_start;
   logic              blank;
   logic              hide;
   logic [3:0]        an_n;
   logic [6:0]        seg_n;
   logic              dp_n;
   logic [3:0]        an_d;
   logic [6:0]        seg_d;
   logic              dp_d;

   always_comb begin
      frame_start = (d_q == 2'd3) && (cnt_q == '0);
      // Capturing frame data is forwarded so the new frame shows from its very first slot.
      snap_d      = frame_start ? {oh1, oh0, om1, om0} : snap_q;
      blank       = 32'(cnt_q) < BLANK_CYCLES;
      hide        = (d_q == 2'd3) && lz_en && (snap_d[3] == DigitZero);
      an_n        = 4'b0000;
      seg_n       = 7'b0000000;
      dp_n        = 1'b0;
      if (!blank && !hide) begin
         an_n[d_q] = 1'b1;
         seg_n     = snap_d[d_q];
         dp_n      = (d_q == 2'd2) && colon_on_q;
      end
      an_d  = ACTIVE_LOW ? ~an_n  : an_n;
      seg_d = ACTIVE_LOW ? ~seg_n : seg_n;
      dp_d  = ACTIVE_LOW ? ~dp_n  : dp_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         d_q        <= 2'd3;
         snap_q     <= '0;
         ccnt_q     <= '0;
         colon_on_q <= 1'b1;
         an         <= {4{ACTIVE_LOW}};
         seg        <= {7{ACTIVE_LOW}};
         dp         <= ACTIVE_LOW;
      end else begin
         snap_q <= snap_d;
         if (cnt_q == CntMax) begin
            cnt_q <= '0;
            d_q   <= d_q - 2'd1;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (ccnt_q == ColMax) begin
            ccnt_q     <= '0;
            colon_on_q <= ~colon_on_q;
         end else begin
            ccnt_q <= ccnt_q + CCW'(1);
         end
         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: per-cycle scoreboard from a time-indexed model,
// a vector table of frames, and hand-written reset, snapshot, colon and random sequences.
module tb_seg_scan_mux;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } out_t;

   typedef struct packed {
      logic [6:0]      oh1;
      logic [6:0]      oh0;
      logic [6:0]      om1;
      logic [6:0]      om0;
      logic            lz;
      logic [3:0][6:0] exp_seg;
      logic            hide3;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] oh1, oh0, om1, om0;
   logic       lz_en;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   int checks = 0;
   int errors = 0;
   int t = 0;
   int tp = 0;
   logic [3:0][6:0] snap = '0;
   out_t sb[$];
   vec_t vecs[4];

   seg_scan_mux #(
      .SCAN_DIV    (4),
      .BLANK_CYCLES(1),
      .COLON_DIV   (32),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .oh1  (oh1),
      .oh0  (oh0),
      .om1  (om1),
      .om0  (om0),
      .lz_en(lz_en),
      .seg  (seg),
      .an   (an),
      .dp   (dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, tp);
      end
   endtask

   // One clock: model predicts the output of this edge, then compares after the edge.
   task automatic step();
      out_t e;
      out_t got;
      int   c;
      int   dd;
      bit   col;
      bit   hide;
      if (t % 16 == 0) snap = {oh1, oh0, om1, om0};
      c    = t % 4;
      dd   = 3 - ((t / 4) % 4);
      col  = ((t / 32) % 2) == 0;
      hide = (dd == 3) && lz_en && (snap[3] == 7'b1111110);
      e.an  = 4'hf;
      e.seg = 7'h7f;
      e.dp  = 1'b1;
      if (c >= 1 && !hide) begin
         e.an[dd] = 1'b0;
         e.seg    = ~snap[dd];
         e.dp     = !(dd == 2 && col);
      end
      sb.push_back(e);
      tp = t;
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("scoreboard", 32'({an, seg, dp}), 32'(got));
      checks++;
      if ($countones(~an) > 1) begin
         errors++;
         $display("FAIL overlap: an=%b has more than one active enable (t=%0d)", an, tp);
      end
      t++;
   endtask

   task automatic align(input int m);
      while (t % m != 0) step();
   endtask

   task automatic set_in(input logic [6:0] a, b, c, d, input logic l);
      oh1 = a; oh0 = b; om1 = c; om0 = d; lz_en = l;
   endtask

   initial begin
      int slot;
      int dd;
      int lowcnt;
      logic [3:0] exp_an;

      vecs[0] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 1'b0,
                  {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 1'b0};
      vecs[1] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111111, 1'b1,
                  {7'b1111111, 7'b1001111, 7'b0010010, 7'b0000000}, 1'b1};
      vecs[2] = '{7'b1111110, 7'b1111001, 7'b0110011, 7'b0000000, 1'b0,
                  {7'b0000001, 7'b0000110, 7'b1001100, 7'b1111111}, 1'b0};
      vecs[3] = '{7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 1'b0,
                  {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 1'b0};

      set_in(vecs[0].oh1, vecs[0].oh0, vecs[0].om1, vecs[0].om0, 1'b0);

      // Held reset
      repeat (3) @(posedge clk);
      #1;
      chk("reset_an", 32'(an), 32'h0000000f);
      chk("reset_seg", 32'(seg), 32'h0000007f);
      chk("reset_dp", 32'(dp), 32'h00000001);
      @(negedge clk);
      rst = 1'b1;
      t   = 0;

      // Vector table: one aligned frame each, digit patterns checked per DRIVE cycle
      for (int v = 0; v < 4; v++) begin
         set_in(vecs[v].oh1, vecs[v].oh0, vecs[v].om1, vecs[v].om0, vecs[v].lz);
         align(16);
         for (int k = 0; k < 16; k++) begin
            step();
            slot = tp % 4;
            dd   = 3 - ((tp / 4) % 4);
            if (slot >= 1) begin
               if (vecs[v].hide3 && dd == 3) begin
                  chk("lz_hidden_an", 32'(an), 32'h0000000f);
               end else begin
                  exp_an     = 4'hf;
                  exp_an[dd] = 1'b0;
                  chk("table_an", 32'(an), 32'(exp_an));
                  chk("table_seg", 32'(seg), 32'(vecs[v].exp_seg[dd]));
               end
            end
         end
      end

      // Snapshot: om0 changes during slot 2; slot 0 of this frame keeps the old pattern
      set_in(vecs[0].oh1, vecs[0].oh0, vecs[0].om1, vecs[0].om0, 1'b0);
      align(16);
      repeat (5) step();
      om0 = 7'b1111111;
      while (t % 16 != 13) step();
      repeat (3) begin
         step();
         chk("snap_old_om0", 32'(seg), 32'h0000004c);
      end
      while (t % 16 != 13) step();
      repeat (3) begin
         step();
         chk("snap_new_om0", 32'(seg), 32'h00000000);
      end

      // Colon windows: six dp-low cycles in the on window, none in the off window
      align(64);
      lowcnt = 0;
      repeat (32) begin
         step();
         if (dp == 1'b0) lowcnt++;
      end
      chk("colon_on_window", 32'(lowcnt), 32'd6);
      lowcnt = 0;
      repeat (32) begin
         step();
         if (dp == 1'b0) lowcnt++;
      end
      chk("colon_off_window", 32'(lowcnt), 32'd0);

      // Asynchronous reset mid-slot while a digit is driven
      for (int k = 0; k < 8 && an == 4'hf; k++) step();
      chk("pre_reset_driving", 32'(an != 4'hf), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_an", 32'(an), 32'h0000000f);
      chk("async_reset_seg", 32'(seg), 32'h0000007f);
      chk("async_reset_dp", 32'(dp), 32'h00000001);
      @(negedge clk);
      rst = 1'b1;
      t   = 0;
      sb.delete();

      // Random inputs, including lz_en toggling every cycle
      for (int k = 0; k < 1000; k++) begin
         set_in(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) oh1 = 7'b1111110;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed four-digit seven-segment scanner that sits directly downstream of `sev_clock`. It consumes the four per-digit segment patterns (`oh1`, `oh0`, `om1`, `om0`) and drives one physical multiplexed display: shared segment lines, four digit enables and a blinking colon. Each frame is latched once, so the display never shows a torn hh:mm value.

## Interface
- `SCAN_DIV`, default 4: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, default 1: leading cycles of each slot with all digits off, for anti-ghosting; range 0 to `SCAN_DIV`-1.
- `COLON_DIV`, default 32: clock cycles per colon half-period; must be ≥ 1.
- `ACTIVE_LOW`, default 1: 1 selects active-low `seg`, `an` and `dp` pins; 0 selects active-high.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `oh1`, `oh0`, `om1`, `om0` input 7 each: segment patterns from `sev_clock`, active-high, bit6=a … bit0=g.
- `lz_en` input 1: enables leading-zero blanking of `oh1`.
- `seg` output 7: shared segment lines, bit6=a … bit0=g.
- `an` output 4: digit enables; an[3]=`oh1`, an[2]=`oh0`, an[1]=`om1`, an[0]=`om0`.
- `dp` output 1: colon/decimal point, shown on the `oh0` digit.

## Operation
- Slot counter `cnt` counts 0 to `SCAN_DIV`-1.
- Digit index `d` (2 bits) steps 3→2→1→0→3. It advances when `cnt` wraps.
- Each slot has two phases:
  - BLANK phase while `cnt` < `BLANK_CYCLES`.
  - DRIVE phase for the remaining cycles.
- Frame start is `d`=3 with `cnt`=0. On that edge, and on the first edge after reset release, all four inputs are copied into snapshot registers. Only snapshot values are displayed.
- In DRIVE phase of slot `d`:
  - the digit-enable bit for `d` is active and all other enables are inactive;
  - `seg` carries the snapshot pattern for `d`.
- In BLANK phase:
  - all enables are inactive;
  - `seg` is all-off;
  - `dp` is off.
- Leading-zero blanking: if `lz_en`=1 and snapshot `oh1` = 7'b1111110 ('0'), slot 3 keeps all enables inactive for the whole slot. The slot still takes its full `SCAN_DIV` cycles, so scan timing is unchanged. `lz_en` is sampled every cycle.
- Colon:
  - A free-running counter counts 0 to `COLON_DIV`-1 and toggles `colon_on` at each wrap.
  - `dp` is active only during the DRIVE phase of slot 2 while `colon_on`=1.
- Polarity:
  - With `ACTIVE_LOW`=1, "active" is 0 on `an` and `dp`, and a lit segment is 0 on `seg`; `seg` = ~pattern.
  - With `ACTIVE_LOW`=0, all three are positive-true.
- Width rules:
  - `cnt` is $clog2(`SCAN_DIV`) bits.
  - The colon counter is $clog2(`COLON_DIV`) bits, minimum 1.
  - No arithmetic is performed on segment data.

## Timing
- `seg`, `an` and `dp` are registered. Each reflects the `cnt`/`d` state of the previous cycle (1-cycle latency).
- Frame length is 4×`SCAN_DIV` cycles.
- Input-to-display latency:
  - An input change is shown starting at the first frame start after the change, plus 1 cycle.
  - Worst case is 4×`SCAN_DIV`+1 cycles.
- Reset, asserted asynchronously, forces the following immediately, including mid-slot:
  - `cnt`=0, `d`=3, snapshots=0, colon counter=0, `colon_on`=1;
  - outputs to the inactive state: with `ACTIVE_LOW`=1, `an`=4'b1111, `seg`=7'b1111111, `dp`=1.
- After reset release, the first slot is `d`=3 and starts in its BLANK phase when `BLANK_CYCLES` > 0.
- If `BLANK_CYCLES`=0, enables switch directly from one digit to the next. No cycle ever has two enables active.
- An input change on the frame-start edge itself is captured on that edge, with normal register setup.

## Test plan
All scenarios use `SCAN_DIV`=4, `BLANK_CYCLES`=1, `COLON_DIV`=32, `ACTIVE_LOW`=1, `lz_en`=0 unless stated.
- **Reset:** hold `rst`=0 → `an`=1111, `seg`=1111111, `dp`=1. Assert `rst`=0 mid-slot → the same values appear immediately, without waiting for a clock edge.
- **Scan order:** inputs `oh1`=0110000, `oh0`=1101101, `om1`=1111001, `om0`=0110011.
  - `an` repeats: 1111, 0111×3, 1111, 1011×3, 1111, 1101×3, 1111, 1110×3.
  - `seg` during those DRIVE runs: 1001111, 0010010, 0000110, 1001100.
- **Snapshot:** change `om0` to 1111111 during slot 2 → slot 0 of the current frame still shows 1001100; the next frame shows 0000000.
- **Leading zero:**
  - `oh1`=1111110 with `lz_en`=1 → an[3] never goes to 0 and frame length stays 16 cycles.
  - Same `oh1` with `lz_en`=0 → `seg`=0000001 while an=0111.
- **Colon:** `dp`=0 only in cycles where `an`=1011 while `colon_on`=1. `colon_on` starts at 1 after reset and toggles every 32 clocks, giving 32-cycle on and 32-cycle off windows.
- **No overlap:** run 1000 cycles with random inputs → `an` never has more than one 0 bit.
